// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared constants, next-state cases and control decode for the dff cell
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 1;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    BOTH   = 3'd1,
    CLEAR  = 3'd2,
    PRESET = 3'd3,
    LOAD   = 3'd4
  } next_op_e;

  // Priority order matches a 7474 with a synchronous global reset layered on top.
  function automatic next_op_e decode_op(input logic rst, input logic pre_n, input logic clr_n);
    if (rst)
      return RESET;
    else if (!pre_n && !clr_n)
      return BOTH;
    else if (!clr_n)
      return CLEAR;
    else if (!pre_n)
      return PRESET;
    else
      return LOAD;
  endfunction

endpackage

// File: rtl/dff_if.sv
// rtl/dff_if.sv - signal bundle for driving and observing one dff instance
interface dff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             pre_n;
  logic             clr_n;
  logic             rst;

  modport master (output d, output pre_n, output clr_n, output rst, input q, input q_n);
  modport slave  (input d, input pre_n, input clr_n, input rst, output q, output q_n);
endinterface

// File: rtl/dff_cell.sv
// rtl/dff_cell.sv - one stored bit with its "both controls low" flag
module dff_cell
  import dff_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic     clk,
  input  next_op_e op,
  input  logic     d,
  output logic     q,
  output logic     q_n,
  output logic     both
);

  logic s;
  logic both_q;

  always_ff @(posedge clk) begin
    case (op)
      RESET: begin
        s      <= RESET_BIT;
        both_q <= 1'b0;
      end
      BOTH: begin
        s      <= 1'b1;
        both_q <= 1'b1;
      end
      CLEAR: begin
        s      <= 1'b0;
        both_q <= 1'b0;
      end
      PRESET: begin
        s      <= 1'b1;
        both_q <= 1'b0;
      end
      default: begin
        s      <= d;
        both_q <= 1'b0;
      end
    endcase
  end

  // With both controls low the complement output is forced high alongside q.
  assign q    = s;
  assign q_n  = both_q ? 1'b1 : ~s;
  assign both = both_q;

endmodule

// File: rtl/dff.sv
// rtl/dff.sv - WIDTH-bit D register with complement output and synchronous preset/clear
module dff
  import dff_pkg::*;
#(
  parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_N,
  input  logic [WIDTH-1:0] D,
  input  logic             CLK,
  input  logic             PRE_N,
  input  logic             CLR_N,
  input  logic             RST
);

  next_op_e         op;
  logic [WIDTH-1:0] both_vec;

  assign op = decode_op(RST, PRE_N, CLR_N);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk  (CLK),
      .op   (op),
      .d    (D[i]),
      .q    (Q[i]),
      .q_n  (Q_N[i]),
      .both (both_vec[i])
    );

    // Outside the both-low state the outputs must be exact complements; X on D is tolerated.
    a_complement: assert property (@(posedge CLK) both_vec[i] || (Q_N[i] === ~Q[i]));
  end

  a_ctrl_known: assert property (@(posedge CLK) !$isunknown({RST, PRE_N, CLR_N}));

endmodule

// File: tb/tb_dff.sv
// tb/tb_dff.sv - directed checks of the dff register at widths 1 and 4
module tb_dff;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dff_if #(.WIDTH(1)) b1 ();
  dff_if #(.WIDTH(4)) b4 ();

  dff u_dut1 (
    .Q     (b1.q),
    .Q_N   (b1.q_n),
    .D     (b1.d),
    .CLK   (clk),
    .PRE_N (b1.pre_n),
    .CLR_N (b1.clr_n),
    .RST   (b1.rst)
  );

  dff #(
    .WIDTH       (4),
    .RESET_VALUE (4'hA)
  ) u_dut4 (
    .Q     (b4.q),
    .Q_N   (b4.q_n),
    .D     (b4.d),
    .CLK   (clk),
    .PRE_N (b4.pre_n),
    .CLR_N (b4.clr_n),
    .RST   (b4.rst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b1.rst = 1'b1; b1.pre_n = 1'b1; b1.clr_n = 1'b1; b1.d = 1'b1;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b01) begin errors++; $display("FAIL reset: q,q_n=%b required 01", {b1.q, b1.q_n}); end
  endtask

  task automatic test_load();
    b1.rst = 1'b0; b1.d = 1'b1;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b10) begin errors++; $display("FAIL load_one: q,q_n=%b required 10", {b1.q, b1.q_n}); end
    b1.d = 1'b0;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b01) begin errors++; $display("FAIL load_zero: q,q_n=%b required 01", {b1.q, b1.q_n}); end
  endtask

  task automatic test_clear();
    b1.d = 1'b1;
    tick();
    b1.clr_n = 1'b0;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b01) begin errors++; $display("FAIL clear: q,q_n=%b required 01", {b1.q, b1.q_n}); end
    b1.d = 1'b0;
    tick();
    b1.d = 1'b1;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b01) begin errors++; $display("FAIL clear_hold: q,q_n=%b required 01", {b1.q, b1.q_n}); end
    b1.clr_n = 1'b1;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b10) begin errors++; $display("FAIL clear_release: q,q_n=%b required 10", {b1.q, b1.q_n}); end
  endtask

  task automatic test_preset();
    b1.d = 1'b0;
    tick();
    b1.pre_n = 1'b0;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b10) begin errors++; $display("FAIL preset: q,q_n=%b required 10", {b1.q, b1.q_n}); end
    b1.pre_n = 1'b1;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b01) begin errors++; $display("FAIL preset_release: q,q_n=%b required 01", {b1.q, b1.q_n}); end
  endtask

  task automatic test_both();
    b1.pre_n = 1'b0; b1.clr_n = 1'b0; b1.d = 1'b0;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b11) begin errors++; $display("FAIL both_low: q,q_n=%b required 11", {b1.q, b1.q_n}); end
    b1.pre_n = 1'b1; b1.clr_n = 1'b1;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b01) begin errors++; $display("FAIL both_release: q,q_n=%b required 01", {b1.q, b1.q_n}); end
  endtask

  task automatic test_priority();
    b1.d = 1'b1;
    tick();
    b1.rst = 1'b1; b1.pre_n = 1'b0;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b01) begin errors++; $display("FAIL rst_over_preset: q,q_n=%b required 01", {b1.q, b1.q_n}); end
    b1.rst = 1'b0; b1.pre_n = 1'b1;
  endtask

  task automatic test_timing();
    b1.d = 1'b1;
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b10) begin errors++; $display("FAIL timing_load: q,q_n=%b required 10", {b1.q, b1.q_n}); end
    b1.d = 1'b0;
    #2;
    checks++; if ({b1.q, b1.q_n} !== 2'b10) begin errors++; $display("FAIL timing_hold_a: q,q_n=%b required 10", {b1.q, b1.q_n}); end
    b1.d = 1'b1;
    #2;
    b1.d = 1'b0;
    #2;
    checks++; if ({b1.q, b1.q_n} !== 2'b10) begin errors++; $display("FAIL timing_hold_b: q,q_n=%b required 10", {b1.q, b1.q_n}); end
    tick();
    checks++; if ({b1.q, b1.q_n} !== 2'b01) begin errors++; $display("FAIL timing_edge: q,q_n=%b required 01", {b1.q, b1.q_n}); end
  endtask

  task automatic test_width4();
    b4.rst = 1'b1; b4.pre_n = 1'b1; b4.clr_n = 1'b1; b4.d = 4'hF;
    tick();
    checks++; if ({b4.q, b4.q_n} !== 8'hA5) begin errors++; $display("FAIL w4_reset: q,q_n=%h required a5", {b4.q, b4.q_n}); end
    b4.rst = 1'b0; b4.d = 4'h3;
    tick();
    checks++; if ({b4.q, b4.q_n} !== 8'h3C) begin errors++; $display("FAIL w4_load: q,q_n=%h required 3c", {b4.q, b4.q_n}); end
    b4.clr_n = 1'b0;
    tick();
    checks++; if ({b4.q, b4.q_n} !== 8'h0F) begin errors++; $display("FAIL w4_clear: q,q_n=%h required 0f", {b4.q, b4.q_n}); end
    b4.pre_n = 1'b0;
    tick();
    checks++; if ({b4.q, b4.q_n} !== 8'hFF) begin errors++; $display("FAIL w4_both: q,q_n=%h required ff", {b4.q, b4.q_n}); end
    b4.pre_n = 1'b1; b4.clr_n = 1'b1; b4.d = 4'h5;
    tick();
    checks++; if ({b4.q, b4.q_n} !== 8'h5A) begin errors++; $display("FAIL w4_both_release: q,q_n=%h required 5a", {b4.q, b4.q_n}); end
    b4.pre_n = 1'b0;
    tick();
    checks++; if ({b4.q, b4.q_n} !== 8'hF0) begin errors++; $display("FAIL w4_preset: q,q_n=%h required f0", {b4.q, b4.q_n}); end
    b4.pre_n = 1'b1;
  endtask

  initial begin
    b4.rst = 1'b1; b4.pre_n = 1'b1; b4.clr_n = 1'b1; b4.d = 4'h0;
    test_reset();
    test_load();
    test_clear();
    test_preset();
    test_both();
    test_priority();
    test_timing();
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff.md
Name: dff

Overview:
- Clocked D-type storage primitive with true and complement outputs, plus active-low preset and clear controls.
- Leaf cell used by the TTL-equivalent part models, e.g. the quad 74S175-style register, which instantiates four 1-bit copies with preset tied high and clear driven from the part's CLR_N.
- Parameterised width so one instance can also serve as a multi-bit register bank.

Parameters:
- WIDTH, 1: number of stored bits. D, Q and Q_N are all WIDTH bits wide.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into Q by RST.

Ports:
- CLK, input, 1: clock. All state changes occur on its rising edge only.
- RST, input, 1: synchronous, active-high global reset.
- Q, output, WIDTH: stored value.
- Q_N, output, WIDTH: complement output.
- D, input, WIDTH: data input.
- PRE_N, input, 1: synchronous, active-low preset, common to all bits.
- CLR_N, input, 1: synchronous, active-low clear, common to all bits.
- Positional declaration order is fixed as Q, Q_N, D, CLK, PRE_N, CLR_N, RST, so existing six-argument positional instantiations bind correctly.
- Integrators tie RST to 1'b0 where it is unused. A floating RST is a lint error.

Behaviour:
- Registered state is a WIDTH-bit value S plus a 1-bit flag BOTH.
- Outputs: Q = S. Q_N = BOTH ? all-ones : ~S.
- Evaluation on each rising CLK edge, highest priority first:
  1. RST=1 -> S=RESET_VALUE, BOTH=0.
  2. PRE_N=0 and CLR_N=0 -> S=all-ones, BOTH=1. Q and Q_N both read all-ones, as on a 7474 with both controls low.
  3. CLR_N=0 only -> S=0, BOTH=0.
  4. PRE_N=0 only -> S=all-ones, BOTH=0.
  5. Otherwise -> S=D, BOTH=0.
- Latency is exactly one CLK edge from any input to Q/Q_N. Outputs do not change between edges; there is no asynchronous path.
- Reset values: Q=RESET_VALUE, Q_N=~RESET_VALUE. Default is Q=0, Q_N=1.
- Releasing both controls from the "both asserted" state: on the next edge Q=D and Q_N=~D. No intermediate cycle.
- RST asserted mid-operation overrides PRE_N, CLR_N and D on that same edge.
- Outside the BOTH state, Q_N is always exactly ~Q, bit for bit.
- Width rule: no arithmetic. Bits are independent; only PRE_N, CLR_N and RST are shared across all bits.
- X on D propagates to Q as X. X on a control input is a simulation assertion failure.
- No gate-level propagation delays are modelled in this block. Part models add their own delays externally.

Decomposition:
- Package dff_pkg:
  - localparam DFF_DEFAULT_WIDTH = 1.
  - Enum of the next-state cases: RESET, BOTH, CLEAR, PRESET, LOAD. Used by the priority decoder and by assertions.
- One sub-module, dff_cell: the 1-bit storage element with the same priority logic.
- dff is a generate loop of WIDTH dff_cells plus shared control decode, control X-check assertions and Q_N/Q consistency assertions.

Test Plan:
- Reset and load: RST=1 with D=1 for one edge -> Q=0, Q_N=1. Then RST=0, PRE_N=CLR_N=1, D=1 -> after the next edge Q=1, Q_N=0. D=0 -> Q=0, Q_N=1.
- Clear: Q=1, then CLR_N=0 with D=1 -> after one edge Q=0, Q_N=1. Q holds 0 while CLR_N=0 regardless of D. On CLR_N release with D=1, Q=1 on the following edge.
- Preset: Q=0, then PRE_N=0 with D=0 -> Q=1, Q_N=0. Release with D=0 -> Q=0 on the next edge.
- Both controls low: PRE_N=0, CLR_N=0 -> Q=1, Q_N=1. Release both with D=0 -> next edge Q=0, Q_N=1.
- Priority and timing: RST=1 together with PRE_N=0 -> Q=RESET_VALUE. Toggle D between edges -> Q changes only at rising edges.
- WIDTH=4, RESET_VALUE=4'hA: RST -> Q=A, Q_N=5. D=3 -> Q=3, Q_N=C. CLR_N=0 -> Q=0, Q_N=F.
